ifetch_mem_arb: RTL and testbench

- Shared instruction-memory arbiter upstream of the multi-thread fetch stage.
- Accepts one fetch request per hardware thread and grants one per cycle, round-robin, to a single-port synchronous instruction ROM with 1-cycle read latency.
- Returns each fetched instruction to its thread through a per-thread response register with valid/ready handshake.
- Supports per-thread flush on jump, which discards stale fetches.

---
 rtl/ifetch_mem_arb.sv | 113 +++++++++++
 tb/tb_ifetch_mem_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_mem_arb.sv
// Round-robin arbiter sharing one synchronous instruction ROM between fetch threads.
// Each thread gets a one-entry response holding register with a valid/ready handshake.
module ifetch_mem_arb #(
    parameter int NUM_Threads = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                   clki,
    input  logic                   rsti,
    input  logic [NUM_Threads-1:0] req_valid,
    input  logic [ADDR_W-1:0]      req_pc [NUM_Threads],
    output logic [NUM_Threads-1:0] req_ready,
    input  logic [NUM_Threads-1:0] flush,
    output logic [NUM_Threads-1:0] resp_valid,
    output logic [DATA_W-1:0]      resp_ins [NUM_Threads],
    output logic [ADDR_W-1:0]      resp_pc [NUM_Threads],
    input  logic [NUM_Threads-1:0] resp_ready,
    output logic                   mem_en,
    output logic [ADDR_W-3:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int TID_W = $clog2(NUM_Threads);

    logic [TID_W-1:0]       rr_ptr;
    logic [TID_W-1:0]       inflight_tid;
    logic [TID_W-1:0]       grant_id;
    logic [TID_W-1:0]       grant_next;
    logic                   inflight_valid;
    logic                   inflight_kill;
    logic [ADDR_W-1:0]      inflight_pc;
    logic                   grant_any;
    logic                   complete;
    logic [NUM_Threads-1:0] hold_valid;
    logic [NUM_Threads-1:0] eligible;

    always_comb begin
        for (int i = 0; i < NUM_Threads; i++) begin
            eligible[i] = req_valid[i] && !flush[i] && !hold_valid[i]
                && !(inflight_valid && inflight_tid == TID_W'(i));
        end
    end

    // Scan starts at rr_ptr; grants are suppressed while reset is held.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_Threads; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_Threads;
            if (!rsti && !grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_id  = TID_W'(idx);
            end
        end
    end

    always_comb begin
        grant_next = (grant_id == TID_W'(NUM_Threads - 1)) ? '0 : grant_id + 1'b1;
        req_ready  = '0;
        mem_en     = grant_any;
        mem_addr   = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            mem_addr            = req_pc[grant_id][ADDR_W-1:2];
        end
        complete = inflight_valid && !inflight_kill && !flush[inflight_tid];
    end

    assign resp_valid = hold_valid;

    always_ff @(posedge clki or posedge rsti) begin
        if (rsti) begin
            rr_ptr         <= '0;
            inflight_valid <= 1'b0;
            inflight_tid   <= '0;
            inflight_pc    <= '0;
            inflight_kill  <= 1'b0;
            hold_valid     <= '0;
            for (int i = 0; i < NUM_Threads; i++) begin
                resp_ins[i] <= '0;
                resp_pc[i]  <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr         <= grant_next;
                inflight_valid <= 1'b1;
                inflight_tid   <= grant_id;
                inflight_pc    <= req_pc[grant_id];
                inflight_kill  <= 1'b0;
            end else begin
                inflight_valid <= 1'b0;
                if (inflight_valid && flush[inflight_tid]) begin
                    inflight_kill <= 1'b1;
                end
            end
            // Flush wins over both completion and consumption for its thread.
            for (int i = 0; i < NUM_Threads; i++) begin
                if (flush[i]) begin
                    hold_valid[i] <= 1'b0;
                end else if (complete && inflight_tid == TID_W'(i)) begin
                    hold_valid[i] <= 1'b1;
                    resp_ins[i]   <= mem_rdata;
                    resp_pc[i]    <= inflight_pc;
                end else if (hold_valid[i] && resp_ready[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_mem_arb.sv
// Self-checking bench for ifetch_mem_arb: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the arbiter.
module tb_ifetch_mem_arb;

    localparam int N = 4;

    logic          clki = 1'b0;
    logic          rsti;
    logic [N-1:0]  req_valid;
    logic [31:0]   req_pc [N];
    logic [N-1:0]  req_ready;
    logic [N-1:0]  flush;
    logic [N-1:0]  resp_valid;
    logic [31:0]   resp_ins [N];
    logic [31:0]   resp_pc [N];
    logic [N-1:0]  resp_ready;
    logic          mem_en;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_hold [N];
    logic [31:0] m_ins [N];
    logic [31:0] m_pc [N];
    bit          m_if_valid;
    int          m_if_tid;
    logic [31:0] m_if_pc;
    int          m_rr;

    int          exp_g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_hold;
    logic        exp_en;
    logic [29:0] exp_addr;

    always #5 clki = ~clki;

    ifetch_mem_arb #(.NUM_Threads(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clki(clki),
        .rsti(rsti),
        .req_valid(req_valid),
        .req_pc(req_pc),
        .req_ready(req_ready),
        .flush(flush),
        .resp_valid(resp_valid),
        .resp_ins(resp_ins),
        .resp_pc(resp_pc),
        .resp_ready(resp_ready),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata)
    );

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_hold[i] = 0;
            m_ins[i]  = '0;
            m_pc[i]   = '0;
        end
        m_if_valid = 0;
        m_if_tid   = 0;
        m_if_pc    = '0;
        m_rr       = 0;
    endfunction

    // Expected grant: first thread, starting after the last winner, that asks,
    // is not flushed, has an empty response slot and no fetch outstanding.
    function automatic void model_predict();
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (exp_g < 0 && req_valid[i] && !flush[i] && !m_hold[i]
                && !(m_if_valid && m_if_tid == i))
                exp_g = i;
        end
        exp_ready = '0;
        exp_en    = 1'b0;
        exp_addr  = '0;
        if (exp_g >= 0) begin
            exp_ready[exp_g] = 1'b1;
            exp_en           = 1'b1;
            exp_addr         = req_pc[exp_g][31:2];
        end
        for (int i = 0; i < N; i++) exp_hold[i] = m_hold[i];
    endfunction

    function automatic void model_update();
        for (int i = 0; i < N; i++)
            if (flush[i] || (m_hold[i] && resp_ready[i])) m_hold[i] = 0;
        if (m_if_valid && !flush[m_if_tid]) begin
            m_hold[m_if_tid] = 1;
            m_ins[m_if_tid]  = mem_rdata;
            m_pc[m_if_tid]   = m_if_pc;
        end
        m_if_valid = (exp_g >= 0);
        if (exp_g >= 0) begin
            m_if_tid = exp_g;
            m_if_pc  = req_pc[exp_g];
            m_rr     = (exp_g + 1) % N;
        end
    endfunction

    task automatic settle();
        #1;
        model_predict();
    endtask

    task automatic advance();
        model_update();
        @(posedge clki);
        @(negedge clki);
    endtask

    task automatic idle_inputs();
        req_valid  = '0;
        flush      = '0;
        resp_ready = '0;
        mem_rdata  = $urandom;
        for (int i = 0; i < N; i++) req_pc[i] = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsti = 1'b1;
        model_reset();
        @(posedge clki);
        @(negedge clki);
        rsti = 1'b0;
    endtask

    task automatic test_reset();
        bit zero_ok;
        idle_inputs();
        rsti = 1'b1;
        req_valid = '1;
        model_reset();
        #1;
        zero_ok = 1;
        for (int i = 0; i < N; i++)
            if (resp_ins[i] !== 32'h0 || resp_pc[i] !== 32'h0) zero_ok = 0;
        n_checks++;
        if (resp_valid !== 4'b0000 || mem_en !== 1'b0 || mem_addr !== 30'h0 || !zero_ok) begin
            n_fail++;
            $display("FAIL reset_state: resp_valid=%b mem_en=%b mem_addr=%h regs_zero=%0d, need 0000 0 0 1",
                     resp_valid, mem_en, mem_addr, zero_ok);
        end
        @(posedge clki);
        @(negedge clki);
        rsti = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            advance();
        end
        settle();
        n_checks++;
        if (resp_valid !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_setup_hold: resp_valid=%b need 0011", resp_valid);
        end
        #1 rsti = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 4'b0000 || mem_en !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midstream: resp_valid=%b mem_en=%b req_ready=%b need 0000 0 0000",
                     resp_valid, mem_en, req_ready);
        end
        model_reset();
        @(posedge clki);
        @(negedge clki);
        rsti = 1'b0;
        settle();
        n_checks++;
        if (req_ready !== 4'b0001 || mem_addr !== req_pc[0][31:2]) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b mem_addr=%h need 0001 %h",
                     req_ready, mem_addr, req_pc[0][31:2]);
        end
        advance();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        req_pc[0] = 32'h0000_0010;
        settle();
        n_checks++;
        if (req_ready !== 4'b0001 || mem_en !== 1'b1 || mem_addr !== 30'h4) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b mem_en=%b mem_addr=%h need 0001 1 4",
                     req_ready, mem_en, mem_addr);
        end
        advance();
        req_valid = '0;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        n_checks++;
        if (resp_valid !== 4'b0000 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: resp_valid=%b mem_en=%b need 0000 0", resp_valid, mem_en);
        end
        advance();
        mem_rdata = $urandom;
        settle();
        n_checks++;
        if (resp_valid !== 4'b0001 || resp_ins[0] !== 32'hDEAD_BEEF || resp_pc[0] !== 32'h10) begin
            n_fail++;
            $display("FAIL single_resp: valid=%b ins=%h pc=%h need 0001 deadbeef 10",
                     resp_valid, resp_ins[0], resp_pc[0]);
        end
        resp_ready = 4'b0001;
        advance();
        resp_ready = '0;
        settle();
        n_checks++;
        if (resp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_consume: resp_valid=%b need 0000", resp_valid);
        end
    endtask

    task automatic test_rotation();
        int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [N-1:0] want;
        do_reset();
        req_valid  = '1;
        resp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) req_pc[i] = $urandom;
            mem_rdata = $urandom;
            settle();
            want = '0;
            want[seq[c]] = 1'b1;
            n_checks++;
            if (req_ready !== want || mem_en !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation_c%0d: req_ready=%b mem_en=%b need %b 1",
                         c + 1, req_ready, mem_en, want);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        bit granted1;
        do_reset();
        req_valid  = '1;
        resp_ready = 4'b1101;
        for (int c = 1; c <= 12; c++) begin
            for (int i = 0; i < N; i++) req_pc[i] = $urandom;
            mem_rdata = $urandom;
            settle();
            if (c >= 3) begin
                n_checks++;
                if (req_ready[1] !== 1'b0 || mem_en !== 1'b1 || req_ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL backpressure_grant_c%0d: req_ready=%b mem_en=%b need %b 1",
                             c, req_ready, mem_en, exp_ready);
                end
            end
            if (c >= 4) begin
                n_checks++;
                if (resp_valid[1] !== 1'b1 || resp_ins[1] !== m_ins[1] || resp_pc[1] !== m_pc[1]) begin
                    n_fail++;
                    $display("FAIL backpressure_hold_c%0d: valid=%b ins=%h pc=%h need 1 %h %h",
                             c, resp_valid[1], resp_ins[1], resp_pc[1], m_ins[1], m_pc[1]);
                end
            end
            advance();
        end
        resp_ready = 4'b1111;
        settle();
        advance();
        resp_ready = 4'b1101;
        granted1 = 0;
        for (int c = 0; c < 6; c++) begin
            settle();
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL backpressure_release_c%0d: req_ready=%b need %b", c, req_ready, exp_ready);
            end
            if (req_ready[1] === 1'b1) granted1 = 1;
            advance();
        end
        n_checks++;
        if (!granted1) begin
            n_fail++;
            $display("FAIL backpressure_regrant: thread1 granted=0 need 1 within 6 cycles");
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        req_valid = 4'b0100;
        req_pc[2] = 32'h0000_0100;
        settle();
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL flushinf_grant: req_ready=%b need 0100", req_ready);
        end
        advance();
        req_valid = '0;
        flush     = 4'b0100;
        mem_rdata = 32'h1111_1111;
        settle();
        advance();
        flush     = '0;
        req_valid = 4'b0100;
        req_pc[2] = 32'h0000_0204;
        settle();
        n_checks++;
        if (resp_valid[2] !== 1'b0 || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL flushinf_discard: resp_valid2=%b req_ready=%b need 0 0100",
                     resp_valid[2], req_ready);
        end
        advance();
        req_valid = '0;
        mem_rdata = 32'h2222_2222;
        settle();
        advance();
        settle();
        n_checks++;
        if (resp_valid[2] !== 1'b1 || resp_ins[2] !== 32'h2222_2222 || resp_pc[2] !== 32'h204) begin
            n_fail++;
            $display("FAIL flushinf_new: valid=%b ins=%h pc=%h need 1 22222222 204",
                     resp_valid[2], resp_ins[2], resp_pc[2]);
        end
    endtask

    task automatic test_flush_hold();
        do_reset();
        req_valid = 4'b1000;
        req_pc[3] = 32'h0000_0300;
        settle();
        advance();
        req_valid = '0;
        mem_rdata = 32'hCAFE_F00D;
        settle();
        advance();
        flush      = 4'b1000;
        resp_ready = 4'b1000;
        req_valid  = 4'b1000;
        settle();
        n_checks++;
        if (req_ready !== 4'b0000 || resp_valid[3] !== 1'b1 || resp_ins[3] !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL flushhold_cycle: req_ready=%b valid3=%b ins3=%h need 0000 1 cafef00d",
                     req_ready, resp_valid[3], resp_ins[3]);
        end
        advance();
        flush      = '0;
        resp_ready = '0;
        settle();
        n_checks++;
        if (resp_valid[3] !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL flushhold_after: valid3=%b req_ready=%b need 0 1000", resp_valid[3], req_ready);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i]  = ($urandom_range(0, 3) != 0);
                flush[i]      = ($urandom_range(0, 9) == 0);
                resp_ready[i] = $urandom_range(0, 1);
                req_pc[i]     = $urandom;
            end
            mem_rdata = $urandom;
            settle();
            n_checks++;
            if (req_ready !== exp_ready || mem_en !== exp_en || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL random_grant_c%0d: ready=%b en=%b addr=%h need %b %b %h",
                         c, req_ready, mem_en, mem_addr, exp_ready, exp_en, exp_addr);
            end
            n_checks++;
            if (resp_valid !== exp_hold) begin
                n_fail++;
                $display("FAIL random_valid_c%0d: resp_valid=%b need %b", c, resp_valid, exp_hold);
            end
            for (int i = 0; i < N; i++) begin
                if (exp_hold[i]) begin
                    n_checks++;
                    if (resp_ins[i] !== m_ins[i] || resp_pc[i] !== m_pc[i]) begin
                        n_fail++;
                        $display("FAIL random_data_c%0d_t%0d: ins=%h pc=%h need %h %h",
                                 c, i, resp_ins[i], resp_pc[i], m_ins[i], m_pc[i]);
                    end
                end
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_flush_inflight();
        test_flush_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
